// File: rtl/alu_core.sv
// Single-stage registered ALU: add, sub, and, or.
// Carry/borrow flag is the unsigned bit above the result.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic [1:0]       Opc_i,
    input  logic [WIDTH-1:0] DinA_i,
    input  logic [WIDTH-1:0] DinB_i,
    output logic [WIDTH-1:0] Dout_o,
    output logic             OverFlow_o
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    logic [WIDTH:0]   w_a;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_res;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;

    assign w_a = {1'b0, DinA_i};
    assign w_b = {1'b0, DinB_i};

    // Top bit of the widened difference is the unsigned borrow.
    always_comb begin
        w_res = '0;
        unique case (Opc_i)
            OP_ADD: w_res = w_a + w_b;
            OP_SUB: w_res = w_a - w_b;
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_dout <= w_res[WIDTH-1:0];
            r_ovf  <= w_res[WIDTH];
        end
    end

    assign Dout_o     = r_dout;
    assign OverFlow_o = r_ovf;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed literal vectors plus
// an arithmetic reference model compared every cycle.
module tb_alu_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   opc = 2'd0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] dout;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [W-1:0] m_dout;
    logic         m_ovf;

    alu_core #(.WIDTH(W)) dut (
        .Clk_i      (clk),
        .Reset_i    (rst),
        .Opc_i      (opc),
        .DinA_i     (a),
        .DinB_i     (b),
        .Dout_o     (dout),
        .OverFlow_o (ovf)
    );

    always #5 clk = ~clk;

    // Plain-arithmetic reference for one operation.
    function automatic void ref_op(
        input  logic [1:0]   op,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        output logic [W-1:0] d,
        output logic         o
    );
        longint unsigned full;
        longint unsigned sx;
        longint unsigned sy;
        longint unsigned s;
        full = 64'd1 << W;
        sx = 64'(x);
        sy = 64'(y);
        d = '0;
        o = 1'b0;
        case (op)
            2'd0: begin
                s = sx + sy;
                d = W'(s % full);
                o = (s >= full);
            end
            2'd1: begin
                s = (sx + full - sy) % full;
                d = W'(s);
                o = (sx < sy);
            end
            2'd2: d = x & y;
            default: d = x | y;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] d;
        logic         o;
        if (rst) begin
            m_dout <= '0;
            m_ovf  <= 1'b0;
        end else begin
            ref_op(opc, a, b, d, o);
            m_dout <= d;
            m_ovf  <= o;
        end
    end

    task automatic check(
        input string        name,
        input logic [W-1:0] gd,
        input logic [W-1:0] ed,
        input logic         go,
        input logic         eo
    );
        checks = checks + 1;
        if (gd !== ed || go !== eo) begin
            errors = errors + 1;
            $display("FAIL %s: got dout=%h ovf=%b, want dout=%h ovf=%b",
                     name, gd, go, ed, eo);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (rst)
                check("model_rst", dout, '0, ovf, 1'b0);
            else
                check("model", dout, m_dout, ovf, m_ovf);
        end
    end

    task automatic apply(
        input logic [1:0]   op,
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        opc = op;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        logic         o;

        opc = 2'd0;
        a = 32'd5;
        b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checking = 1'b1;
            check("reset_hold", dout, 32'd0, ovf, 1'b0);
        end
        rst = 1'b0;
        #1;
        check("after_release", dout, 32'd0, ovf, 1'b0);
        @(posedge clk);
        #1;
        check("first_add", dout, 32'd12, ovf, 1'b0);

        apply(2'd0, 32'hFFFF_FFFF, 32'h1);
        check("add_carry", dout, 32'h0, ovf, 1'b1);
        apply(2'd0, 32'h7FFF_FFFF, 32'h1);
        check("add_nocarry", dout, 32'h8000_0000, ovf, 1'b0);
        apply(2'd1, 32'd3, 32'd5);
        check("sub_borrow", dout, 32'hFFFF_FFFE, ovf, 1'b1);
        apply(2'd1, 32'd5, 32'd5);
        check("sub_equal", dout, 32'h0, ovf, 1'b0);
        apply(2'd2, 32'hF0F0_1234, 32'hFF00_FF00);
        check("and", dout, 32'hF000_1200, ovf, 1'b0);
        apply(2'd3, 32'hF0F0_1234, 32'hFF00_FF00);
        check("or", dout, 32'hFFF0_FF34, ovf, 1'b0);

        apply(2'd0, 32'd1, 32'd2);
        check("b2b_add", dout, 32'd3, ovf, 1'b0);
        apply(2'd1, 32'd9, 32'd4);
        check("b2b_sub", dout, 32'd5, ovf, 1'b0);
        apply(2'd2, 32'd6, 32'd3);
        check("b2b_and", dout, 32'd2, ovf, 1'b0);
        apply(2'd3, 32'd8, 32'd1);
        check("b2b_or", dout, 32'd9, ovf, 1'b0);

        opc = 2'd0;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dout, 32'd0, ovf, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_held", dout, 32'd0, ovf, 1'b0);
        end
        rst = 1'b0;
        apply(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("post_rst_add", dout, 32'hFFFF_FFFE, ovf, 1'b1);

        ref_op(2'd1, 32'd0, 32'd1, d, o);
        check("model_pin_sub", d, 32'hFFFF_FFFF, o, 1'b1);
        ref_op(2'd0, 32'h8000_0000, 32'h8000_0000, d, o);
        check("model_pin_add", d, 32'h0, o, 1'b1);

        for (int i = 0; i < 40; i++) begin
            opc = 2'($urandom_range(0, 3));
            a = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (i % 7 == 0) ? a : $urandom;
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
